inst_fetch_queue: RTL and testbench

- Instruction fetch queue between a combinational instruction cache and the dispatch stage.
- Fetches aligned 128-bit lines (4 instructions) at a fetch PC and buffers up to DEPTH lines.
- Hands out one 32-bit instruction with its PC per pop.
- Flushes and redirects fetch on a jump/branch.

---
 rtl/inst_fetch_queue.sv | 103 ++++++++++
 tb/tb_inst_fetch_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: buffers aligned 128-bit cache lines and hands out one
// 32-bit instruction with its PC per pop; a jump/branch flushes and redirects.
// Optional macro IFQ_BYPASS_EN: a line filled into an empty queue is visible
// in the same cycle.
`timescale 1ns/1ps
module inst_fetch_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   output logic [31:0]  pc_in,
   output logic         cache_rd_en,
   output logic         cache_abort,
   input  logic [127:0] dout,
   input  logic         dout_valid,
   output logic [31:0]  pc_out,
   output logic [31:0]  inst,
   output logic         empty,
   input  logic         inst_rd_en,
   input  logic [31:0]  jmp_branch_address,
   input  logic         jmp_branch_valid
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;

   logic [127:0]  mem [DEPTH];
   logic [PW-1:0] wp, rl, wp_nxt, rl_nxt;
   logic [1:0]    ro, ro_nxt;
   logic [31:0]   pc_in_nxt, pc_out_nxt;
   logic          full, ptr_empty, fill, pop;
   logic [127:0]  head_line;

   // Queue status from the wrap-bit pointers
   always_comb begin
      ptr_empty = (wp == rl);
      full      = (wp[AW-1:0] == rl[AW-1:0]) && (wp[AW] != rl[AW]);
   end

   assign cache_rd_en = ~full;
   assign cache_abort = jmp_branch_valid;
   assign fill        = cache_rd_en & dout_valid & ~jmp_branch_valid;

`ifdef IFQ_BYPASS_EN
   assign empty     = ptr_empty & ~fill;
   assign head_line = ptr_empty ? dout : mem[rl[AW-1:0]];
`else
   assign empty     = ptr_empty;
   assign head_line = mem[rl[AW-1:0]];
`endif

   assign pop  = inst_rd_en & ~empty & ~jmp_branch_valid;
   assign inst = head_line[{ro, 5'b0} +: 32];

   // Next-state: redirect overrides fill and pop
   always_comb begin
      wp_nxt     = wp;
      rl_nxt     = rl;
      ro_nxt     = ro;
      pc_in_nxt  = pc_in;
      pc_out_nxt = pc_out;
      if (jmp_branch_valid) begin
         wp_nxt     = '0;
         rl_nxt     = '0;
         ro_nxt     = jmp_branch_address[3:2];
         pc_in_nxt  = jmp_branch_address & ~32'hF;
         pc_out_nxt = jmp_branch_address & ~32'h3;
      end else begin
         if (fill) begin
            wp_nxt    = wp + PW'(1);
            pc_in_nxt = pc_in + 32'd16;
         end
         if (pop) begin
            ro_nxt     = ro + 2'd1;
            pc_out_nxt = pc_out + 32'd4;
            if (ro == 2'd3) rl_nxt = rl + PW'(1);
         end
      end
   end

   // Pointer and PC registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp     <= '0;
         rl     <= '0;
         ro     <= '0;
         pc_in  <= '0;
         pc_out <= '0;
      end else begin
         wp     <= wp_nxt;
         rl     <= rl_nxt;
         ro     <= ro_nxt;
         pc_in  <= pc_in_nxt;
         pc_out <= pc_out_nxt;
      end
   end

   // Line storage; contents need no reset
   always_ff @(posedge clk) begin
      if (fill) mem[wp[AW-1:0]] <= dout;
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: randomized bench with a line-queue reference model and
// a scoreboard that checks every popped instruction and PC.
`timescale 1ns/1ps
module tb_inst_fetch_queue;

   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [31:0]  pc_in;
   logic         cache_rd_en;
   logic         cache_abort;
   logic [127:0] dout;
   logic         dout_valid;
   logic [31:0]  pc_out;
   logic [31:0]  inst;
   logic         empty;
   logic         inst_rd_en;
   logic [31:0]  jmp_branch_address;
   logic         jmp_branch_valid;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: lines held in the queue, fetch PC, head PC, data salt
   logic [127:0] lines [$];
   logic [31:0]  fpc_m = 32'h0;
   logic [31:0]  hpc_m = 32'h0;
   logic [31:0]  salt  = 32'h5A5A_0001;
   exp_t         exp_q [$];

   inst_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .cache_rd_en(cache_rd_en),
      .cache_abort(cache_abort), .dout(dout), .dout_valid(dout_valid),
      .pc_out(pc_out), .inst(inst), .empty(empty), .inst_rd_en(inst_rd_en),
      .jmp_branch_address(jmp_branch_address), .jmp_branch_valid(jmp_branch_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] wd(input logic [31:0] a, input logic [31:0] s);
      return (a * 32'h9E37_79B1) ^ s;
   endfunction

   function automatic logic [127:0] mk_line(input logic [31:0] base, input logic [31:0] s);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[32*k +: 32] = wd(base + 32'(4*k), s);
      return l;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // One clock of stimulus; checks visible outputs, predicts pops, advances model
   task automatic step(input bit dv, input bit ird, input bit jv, input logic [31:0] addr);
      bit fill_m, vis_empty, pop_m;
      logic [127:0] head;
      exp_t e;
      @(negedge clk);
      dout               = mk_line(fpc_m, salt);
      dout_valid         = dv;
      inst_rd_en         = ird;
      jmp_branch_valid   = jv;
      jmp_branch_address = addr;
      #1;
      fill_m = (lines.size() < DEPTH) && dv && !jv;
`ifdef IFQ_BYPASS_EN
      vis_empty = (lines.size() == 0) && !fill_m;
`else
      vis_empty = (lines.size() == 0);
`endif
      pop_m = ird && !vis_empty && !jv;
      chk("pc_in", 64'(pc_in), 64'(fpc_m));
      chk("cache_rd_en", 64'(cache_rd_en), 64'(lines.size() < DEPTH));
      chk("cache_abort", 64'(cache_abort), 64'(jv));
      chk("empty", 64'(empty), 64'(vis_empty));
      chk("pc_out", 64'(pc_out), 64'(hpc_m));
      if (pop_m) begin
         head  = (lines.size() == 0) ? dout : lines[0];
         e.pc  = hpc_m;
         e.ins = head[{hpc_m[3:2], 5'b0} +: 32];
         exp_q.push_back(e);
      end
      if (jv) begin
         lines.delete();
         fpc_m = addr & ~32'hF;
         hpc_m = addr & ~32'h3;
         salt  = $urandom;
      end else begin
         if (fill_m) begin
            lines.push_back(dout);
            fpc_m = fpc_m + 32'd16;
         end
         if (pop_m) begin
            if (hpc_m[3:2] == 2'd3) void'(lines.pop_front());
            hpc_m = hpc_m + 32'd4;
         end
      end
   endtask

   // Monitor: every accepted pop is compared against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst && inst_rd_en && !empty && !jmp_branch_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_pop: got pc %h with no expected entry", pc_out);
            end else begin
               e = exp_q.pop_front();
               chk("pop_pc", 64'(pc_out), 64'(e.pc));
               chk("pop_inst", 64'(inst), 64'(e.ins));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; dout = '0; dout_valid = 1'b0; inst_rd_en = 1'b0;
      jmp_branch_valid = 1'b0; jmp_branch_address = '0;
      #3;
      chk("rst_pc_in", 64'(pc_in), 64'h0);
      chk("rst_pc_out", 64'(pc_out), 64'h0);
      chk("rst_empty", 64'(empty), 64'h1);
      chk("rst_cache_rd_en", 64'(cache_rd_en), 64'h1);
      chk("rst_cache_abort", 64'(cache_abort), 64'h0);
      #9 rst = 1'b1;

      // Fill until full
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      // Drain all 16 instructions
      for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      // Partial refill, pop, then redirect mid-drain
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h104);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      // Drain, then pop while empty
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      // Concurrent fill and pop over many lines
      for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      // Redirect colliding with fill and pop
      step(1'b1, 1'b1, 1'b1, 32'h2000_0008);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      // Fetch PC wrapping past 2^32
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      // Random traffic
      for (int i = 0; i < 2000; i++)
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 99) < 5), $urandom & 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("scoreboard_drain", 64'(exp_q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
